// File: rtl/or1k_cfgrs_spr.sv
// Group-0 SPR access unit: configuration words, multicore IDs, EVBAR and AECR/AECSR
// behind a handshaked mfspr/mtspr port with a configurable read latency.
module or1k_cfgrs_spr #(
    parameter              FEATURE_EVBAR       = "ENABLED",
    parameter              FEATURE_AECSR       = "ENABLED",
    parameter int          AEC_WIDTH           = 7,
    parameter logic [31:0] OPTION_RESET_EVBAR  = 32'h0,
    parameter logic [31:0] OPTION_CORE_ID      = 32'd0,
    parameter logic [31:0] OPTION_NUM_CORES    = 32'd1,
    parameter int          OPTION_READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [351:0]         cfg_words_i,
    input  logic                 spr_access_i,
    input  logic                 spr_we_i,
    input  logic [15:0]          spr_addr_i,
    input  logic [31:0]          spr_dat_i,
    output logic                 spr_ack_o,
    output logic [31:0]          spr_dat_o,
    output logic [31:0]          evbar_o,
    output logic [AEC_WIDTH-1:0] aecr_o,
    input  logic [AEC_WIDTH-1:0] aec_event_i,
    output logic                 aec_exception_o
);

    localparam bit          EVBAR_EN  = (FEATURE_EVBAR == "ENABLED");
    localparam bit          AEC_EN    = (FEATURE_AECSR == "ENABLED");
    localparam bit          COMB_ACK  = (OPTION_READ_LATENCY == 1);
    localparam logic [1:0]  LAT_M1    = 2'(OPTION_READ_LATENCY - 1);
    localparam logic [31:0] EVBAR_RST = EVBAR_EN ? (OPTION_RESET_EVBAR & 32'hffff_e000) : 32'h0;

    localparam logic [10:0] IDX_LAST_CFG = 11'd10;
    localparam logic [10:0] IDX_EVBAR    = 11'd11;
    localparam logic [10:0] IDX_AECR     = 11'd12;
    localparam logic [10:0] IDX_AECSR    = 11'd13;
    localparam logic [10:0] IDX_COREID   = 11'd128;
    localparam logic [10:0] IDX_NUMCORES = 11'd129;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [10:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic                 ack_q, ack_d;
    logic                 blk_q, blk_d;
    logic [31:0]          evbar_q, evbar_d;
    logic [AEC_WIDTH-1:0] aecr_q, aecr_d;
    logic [AEC_WIDTH-1:0] aecsr_q, aecsr_d;
    logic                 exc_q, exc_d;

    logic [31:0]          cfg_w [0:10];
    logic                 req_hit;
    logic                 comb_ack;
    logic                 ack;
    logic [10:0]          rd_idx;
    logic                 rd_we;
    logic                 wr;
    logic [31:0]          rd_data;
    logic [AEC_WIDTH-1:0] cap;
    logic                 unused_dat;

    always_comb begin
        for (int unsigned k = 0; k < 11; k++) begin
            cfg_w[k] = cfg_words_i[32*k +: 32];
        end
    end

    always_comb begin
        req_hit = spr_access_i && (spr_addr_i[15:11] == 5'd0) &&
                  ((spr_addr_i[10:0] <= IDX_AECSR) ||
                   (spr_addr_i[10:0] == IDX_COREID) ||
                   (spr_addr_i[10:0] == IDX_NUMCORES));
    end

    // cnt_q counts cycles still to wait after the current one; ack_q is raised
    // one cycle early so the strobe itself comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        comb_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_hit && !blk_q) begin
                    addr_d = spr_addr_i[10:0];
                    we_d   = spr_we_i;
                    if (COMB_ACK) begin
                        comb_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1 - 2'd1;
                        ack_d   = (LAT_M1 == 2'd1);
                    end
                end
            end
            ST_WAIT: begin
                if (ack_q || !spr_access_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    ack_d = (cnt_q == 2'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack       = COMB_ACK ? comb_ack : ack_q;
        spr_ack_o = ack & ~rst;
        blk_d     = spr_ack_o;
        rd_idx    = COMB_ACK ? spr_addr_i[10:0] : addr_q;
        rd_we     = COMB_ACK ? spr_we_i : we_q;
        wr        = spr_ack_o & rd_we;
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx <= IDX_LAST_CFG) begin
            rd_data = cfg_w[rd_idx[3:0]];
        end else begin
            case (rd_idx)
                IDX_EVBAR:    rd_data = evbar_q;
                IDX_AECR:     rd_data[AEC_WIDTH-1:0] = aecr_q;
                IDX_AECSR:    rd_data[AEC_WIDTH-1:0] = aecsr_q;
                IDX_COREID:   rd_data = OPTION_CORE_ID;
                IDX_NUMCORES: rd_data = OPTION_NUM_CORES;
                default:      rd_data = '0;
            endcase
        end
        spr_dat_o = spr_ack_o ? rd_data : '0;
    end

    // A write to AECSR in the same cycle as a captured event keeps the event bit.
    always_comb begin
        cap     = aec_event_i & aecr_q;
        evbar_d = evbar_q;
        aecr_d  = aecr_q;
        aecsr_d = aecsr_q | cap;
        exc_d   = |cap;
        if (EVBAR_EN && wr && (rd_idx == IDX_EVBAR)) begin
            evbar_d = {spr_dat_i[31:13], 13'b0};
        end
        if (AEC_EN && wr && (rd_idx == IDX_AECR)) begin
            aecr_d = spr_dat_i[AEC_WIDTH-1:0];
        end
        if (AEC_EN && wr && (rd_idx == IDX_AECSR)) begin
            aecsr_d = spr_dat_i[AEC_WIDTH-1:0] | cap;
        end
        unused_dat = ^spr_dat_i[12:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            blk_q   <= 1'b0;
            evbar_q <= EVBAR_RST;
            aecr_q  <= '0;
            aecsr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            blk_q   <= blk_d;
            evbar_q <= evbar_d;
            aecr_q  <= aecr_d;
            aecsr_q <= aecsr_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        evbar_o         = evbar_q;
        aecr_o          = aecr_q;
        aec_exception_o = exc_q;
    end

endmodule

// File: tb/tb_or1k_cfgrs_spr.sv
// Randomized bench for or1k_cfgrs_spr: a latency-1 and a latency-3 instance checked
// cycle by cycle against a rule-level model of the group-0 register file.
module tb_or1k_cfgrs_spr;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [351:0] cfg_words;
    logic         access [2];
    logic         we     [2];
    logic [15:0]  addr   [2];
    logic [31:0]  wdat   [2];
    logic         ack    [2];
    logic [31:0]  rdat   [2];
    logic [31:0]  evbar  [2];
    logic [6:0]   aecr   [2];
    logic [6:0]   ev     [2];
    logic         exc    [2];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] cfg_m     [11];
    int          lat_m     [2] = '{1, 3};
    logic [31:0] core_m    [2] = '{32'd2, 32'd5};
    logic [31:0] ncore_m   [2] = '{32'd4, 32'd8};
    logic [31:0] rstevb_m  [2] = '{32'h0, 32'h1234_5678};
    logic [31:0] evbar_m   [2];
    logic [6:0]  aecr_m    [2];
    logic [6:0]  aecsr_m   [2];
    logic        exc_m     [2];

    logic [15:0] addr_tab [20] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7,
                                   16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd128,
                                   16'd129, 16'd14, 16'd130, 16'h0800, 16'h880C};

    or1k_cfgrs_spr #(
        .OPTION_CORE_ID      (32'd2),
        .OPTION_NUM_CORES    (32'd4),
        .OPTION_READ_LATENCY (1)
    ) u_dut_l1 (
        .clk (clk), .rst (rst), .cfg_words_i (cfg_words),
        .spr_access_i (access[0]), .spr_we_i (we[0]), .spr_addr_i (addr[0]),
        .spr_dat_i (wdat[0]), .spr_ack_o (ack[0]), .spr_dat_o (rdat[0]),
        .evbar_o (evbar[0]), .aecr_o (aecr[0]), .aec_event_i (ev[0]),
        .aec_exception_o (exc[0])
    );

    or1k_cfgrs_spr #(
        .OPTION_RESET_EVBAR  (32'h1234_5678),
        .OPTION_CORE_ID      (32'd5),
        .OPTION_NUM_CORES    (32'd8),
        .OPTION_READ_LATENCY (3)
    ) u_dut_l3 (
        .clk (clk), .rst (rst), .cfg_words_i (cfg_words),
        .spr_access_i (access[1]), .spr_we_i (we[1]), .spr_addr_i (addr[1]),
        .spr_dat_i (wdat[1]), .spr_ack_o (ack[1]), .spr_dat_o (rdat[1]),
        .evbar_o (evbar[1]), .aecr_o (aecr[1]), .aec_event_i (ev[1]),
        .aec_exception_o (exc[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset_all();
        for (int j = 0; j < 2; j++) begin
            evbar_m[j] = rstevb_m[j] & 32'hffff_e000;
            aecr_m[j]  = '0;
            aecsr_m[j] = '0;
            exc_m[j]   = 1'b0;
        end
    endtask

    task automatic set_cfg();
        for (int k = 0; k < 11; k++) cfg_words[32*k +: 32] = cfg_m[k];
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return (a[15:11] == 5'd0) &&
               ((a[10:0] <= 11'd13) || (a[10:0] == 11'd128) || (a[10:0] == 11'd129));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [15:0] a);
        logic [10:0] i;
        i = a[10:0];
        if (i <= 11'd10) return cfg_m[i[3:0]];
        case (i)
            11'd11:  return evbar_m[d];
            11'd12:  return {25'b0, aecr_m[d]};
            11'd13:  return {25'b0, aecsr_m[d]};
            11'd128: return core_m[d];
            11'd129: return ncore_m[d];
            default: return 32'h0;
        endcase
    endfunction

    // One clock of DUT d with inputs already driven; checks outputs then advances the model.
    task automatic tick(input int d, input bit exp_ack, output logic [31:0] seen);
        logic [31:0] exp_rd;
        logic [6:0]  cap;
        exp_rd = model_read(d, addr[d]);
        #1;
        seen = rdat[d];
        check($sformatf("ack d%0d a=%h", d, addr[d]), {31'b0, ack[d]}, {31'b0, exp_ack});
        if (!exp_ack) check($sformatf("idle_dat d%0d", d), rdat[d], 32'h0);
        else if (!we[d]) check($sformatf("rdata d%0d a=%h", d, addr[d]), rdat[d], exp_rd);
        check($sformatf("evbar d%0d", d), evbar[d], evbar_m[d]);
        check($sformatf("aecr d%0d", d), {25'b0, aecr[d]}, {25'b0, aecr_m[d]});
        check($sformatf("exc d%0d", d), {31'b0, exc[d]}, {31'b0, exc_m[d]});
        for (int j = 0; j < 2; j++) begin
            cap        = ev[j] & aecr_m[j];
            exc_m[j]   = |cap;
            aecsr_m[j] = aecsr_m[j] | cap;
            if (j == d && exp_ack && we[j]) begin
                case (addr[j][10:0])
                    11'd11: evbar_m[j] = {wdat[j][31:13], 13'b0};
                    11'd12: aecr_m[j]  = wdat[j][6:0];
                    11'd13: aecsr_m[j] = wdat[j][6:0] | cap;
                    default: ;
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [31:0] wd,
                        input int drop_at, input logic [6:0] ev_ack, input bit rnd_ev,
                        output logic [31:0] rd);
        logic [31:0] seen;
        bit          dropped;
        dropped   = 1'b0;
        rd        = 32'h0;
        access[d] = 1'b1;
        we[d]     = w;
        addr[d]   = a;
        wdat[d]   = wd;
        if (!model_hit(a)) begin
            for (int c = 0; c < 8; c++) begin
                ev[d] = rnd_ev ? 7'($urandom) : 7'h0;
                tick(d, 1'b0, seen);
            end
        end else begin
            for (int c = 0; c < lat_m[d] && !dropped; c++) begin
                ev[d] = rnd_ev ? 7'($urandom) : 7'h0;
                if (drop_at > 0 && c == drop_at) begin
                    access[d] = 1'b0;
                    tick(d, 1'b0, seen);
                    dropped = 1'b1;
                end else if (c == lat_m[d] - 1) begin
                    ev[d] = ev[d] | ev_ack;
                    tick(d, 1'b1, seen);
                    rd = seen;
                end else begin
                    tick(d, 1'b0, seen);
                end
            end
            if (!dropped) begin
                ev[d] = rnd_ev ? 7'($urandom) : 7'h0;
                tick(d, 1'b0, seen);
            end
        end
        access[d] = 1'b0;
        ev[d]     = 7'h0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] seen;
        int          dsel;

        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            access[j] = 1'b0; we[j] = 1'b0; addr[j] = '0; wdat[j] = '0; ev[j] = '0;
        end
        for (int k = 0; k < 11; k++) cfg_m[k] = 32'hA000_0000 + k;
        set_cfg();
        model_reset_all();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        tick(0, 1'b0, seen);
        tick(1, 1'b0, seen);

        for (int k = 0; k <= 10; k++) begin
            xfer(0, 1'b0, 16'(k), 32'h0, 0, 7'h0, 1'b0, rd);
            check($sformatf("cfg_word%0d", k), rd, 32'hA000_0000 + k);
        end
        xfer(0, 1'b0, 16'd129, 32'h0, 0, 7'h0, 1'b0, rd);
        check("numcores", rd, 32'd4);
        xfer(0, 1'b0, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        check("aecsr_reset", rd, 32'h0);
        xfer(0, 1'b0, 16'd14, 32'h0, 0, 7'h0, 1'b0, rd);
        xfer(0, 1'b0, 16'h0800, 32'h0, 0, 7'h0, 1'b0, rd);
        xfer(0, 1'b1, 16'd2, 32'hDEAD_BEEF, 0, 7'h0, 1'b0, rd);
        xfer(0, 1'b0, 16'd2, 32'h0, 0, 7'h0, 1'b0, rd);
        check("ro_write", rd, 32'hA000_0002);

        xfer(0, 1'b1, 16'd12, 32'h10, 0, 7'h0, 1'b0, rd);
        ev[0] = 7'h11;
        tick(0, 1'b0, seen);
        ev[0] = 7'h0;
        repeat (3) tick(0, 1'b0, seen);
        xfer(0, 1'b0, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        check("aecsr_capture", rd, 32'h10);
        xfer(0, 1'b1, 16'd13, 32'h0, 0, 7'h10, 1'b0, rd);
        xfer(0, 1'b0, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        check("capture_wins", rd, 32'h10);
        xfer(0, 1'b1, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        xfer(0, 1'b0, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        check("aecsr_clear", rd, 32'h0);

        xfer(1, 1'b0, 16'd11, 32'h0, 0, 7'h0, 1'b0, rd);
        check("evbar_reset", rd, 32'h1234_4000);
        xfer(1, 1'b1, 16'd11, 32'hFFFF_FFFF, 0, 7'h0, 1'b0, rd);
        xfer(1, 1'b0, 16'd11, 32'h0, 0, 7'h0, 1'b0, rd);
        check("evbar_mask", rd, 32'hFFFF_E000);
        xfer(1, 1'b1, 16'd12, 32'h55, 1, 7'h0, 1'b0, rd);
        xfer(1, 1'b0, 16'd12, 32'h0, 0, 7'h0, 1'b0, rd);
        check("abort_aecr", rd, 32'h0);
        xfer(1, 1'b0, 16'd128, 32'h0, 0, 7'h0, 1'b0, rd);
        check("coreid", rd, 32'd5);

        xfer(1, 1'b1, 16'd12, 32'h7F, 0, 7'h0, 1'b0, rd);
        xfer(1, 1'b1, 16'd13, 32'h3C, 0, 7'h0, 1'b0, rd);
        access[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'd11; wdat[1] = 32'h0;
        tick(1, 1'b0, seen);
        rst = 1'b1;
        #1;
        check("rst_wait_ack", {31'b0, ack[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        access[1] = 1'b0;
        model_reset_all();
        tick(1, 1'b0, seen);
        check("rst_evbar", evbar[1], 32'h1234_4000);
        xfer(1, 1'b0, 16'd12, 32'h0, 0, 7'h0, 1'b0, rd);
        check("rst_aecr", rd, 32'h0);
        xfer(1, 1'b0, 16'd13, 32'h0, 0, 7'h0, 1'b0, rd);
        check("rst_aecsr", rd, 32'h0);

        for (int k = 0; k < 11; k++) cfg_m[k] = $urandom;
        set_cfg();
        for (int n = 0; n < 300; n++) begin
            dsel = n % 2;
            xfer(dsel, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 19)], $urandom,
                 (lat_m[dsel] > 2 && $urandom_range(0, 7) == 0) ? 1 : 0, 7'h0, 1'b1, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or1k_cfgrs_spr.md
# or1k_cfgrs_spr

Group-0 SPR access unit for the or1k control stage: it puts the read-only configuration and version words behind a handshaked `mfspr`/`mtspr` port. It adds the multicore identification registers and owns the writable EVBAR, AECR and AECSR state, including sticky capture of arithmetic exception causes. Read latency is configurable. The block sits beside the control unit's SPR bus and only acknowledges group-0 addresses it owns.

## Interface

Parameters:

- `FEATURE_EVBAR`, default `"ENABLED"`: EVBAR is implemented; when `"NONE"`, address 11 reads 0 and ignores writes.
- `FEATURE_AECSR`, default `"ENABLED"`: AECR/AECSR are implemented; when `"NONE"`, both read 0, ignore writes, and `aec_exception_o` stays 0.
- `AEC_WIDTH`, default 7: number of implemented AECR/AECSR bits, range 1..32; upper bits read 0.
- `OPTION_RESET_EVBAR`, default 32'h0: EVBAR reset value; bits [12:0] are forced to 0.
- `OPTION_CORE_ID`, default 0: value returned by COREID.
- `OPTION_NUM_CORES`, default 1: value returned by NUMCORES.
- `OPTION_READ_LATENCY`, default 1: number of cycles from access to ack, range 1..3.

Ports:

- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `cfg_words_i` in 352: eleven packed read-only words; word k sits in bits [32k+31:32k] and is returned for group-0 address k (0=VR … 10=AVR).
- `spr_access_i` in 1: request valid; held until ack.
- `spr_we_i` in 1: 1 = write (`mtspr`), 0 = read (`mfspr`).
- `spr_addr_i` in 16: full SPR address; bits [15:11] must be 0 for a hit.
- `spr_dat_i` in 32: write data.
- `spr_ack_o` out 1: single-cycle completion strobe.
- `spr_dat_o` out 32: read data; valid only while `spr_ack_o` is high, otherwise 0.
- `evbar_o` out 32: current EVBAR.
- `aecr_o` out `AEC_WIDTH`: current AECR.
- `aec_event_i` in `AEC_WIDTH`: per-cycle arithmetic exception cause pulses.
- `aec_exception_o` out 1: registered; high the cycle after any `aec_event_i & aecr_o` bit is set.

## Operation

- Address map (index in bits [10:0]):
  - 0..10: `cfg_words_i`.
  - 11: EVBAR.
  - 12: AECR.
  - 13: AECSR.
  - 128: COREID.
  - 129: NUMCORES.
- Any other address is a miss: no ack and no state change. Another unit answers it.
- FSM states are IDLE and WAIT.
  - IDLE: a hit access with `spr_access_i` high loads a countdown with `OPTION_READ_LATENCY-1` and latches the address and write flag.
  - If the countdown is 0, ack is asserted in that same cycle and the FSM stays in IDLE. Otherwise the FSM moves to WAIT.
  - WAIT: the counter decrements each cycle. When it reaches 0, ack is asserted and the FSM returns to IDLE.
  - After an ack, the FSM stays in IDLE for one cycle before it can accept a new request, so ack never fires on consecutive cycles.
- Abort: if `spr_access_i` falls in WAIT, the FSM returns to IDLE, no ack is issued, and no write is committed.
- Writes commit only on the ack cycle:
  - EVBAR takes `{spr_dat_i[31:13], 13'b0}`.
  - AECR takes `spr_dat_i[AEC_WIDTH-1:0]`.
  - AECSR takes the written value OR the event bits of that cycle. Capture wins over clear.
  - Writes to read-only addresses are acknowledged and have no effect.
- AECSR capture: every cycle, AECSR |= `aec_event_i & AECR`.
- Read data is sampled on the ack cycle, so it reflects all state updates committed before that cycle.
- Reset values:
  - `spr_ack_o`, `spr_dat_o`, AECR, AECSR, `aec_exception_o`: 0.
  - EVBAR: `OPTION_RESET_EVBAR & 32'hffffe000`.
  - FSM: IDLE.

## Timing

- Latency 1: access in cycle N gives ack in cycle N. This path is combinational from the address to `spr_dat_o`.
- Latency L > 1: ack in cycle N+L-1, registered.
- Register update latency: a committed write is visible to a read acked at least 1 cycle later.
- Event timing: an event in cycle N is visible in AECSR at N+1, and `aec_exception_o` is high at N+1.
- `rst` asserted during WAIT: no ack is issued, and the FSM is in IDLE on the next cycle.
- `rst` has priority over every write and capture.

## Test plan

- Reset, then read addresses 0..10 at latency 1 with `cfg_words_i` word k = 32'hA000_0000+k → ack in the same cycle with data A000_0000+k. Address 129 with `OPTION_NUM_CORES`=4 → 4.
- Latency 3: read address 11 after reset with `OPTION_RESET_EVBAR`=32'h1234_5678 → ack exactly 2 cycles after the access, data 32'h1234_4000. Write 32'hFFFF_FFFF → read back 32'hFFFF_E000.
- Drop `spr_access_i` in WAIT during a write of 0x55 to AECR (latency 3) → no ack, and AECR still reads 0.
- Write AECR=7'h10, pulse `aec_event_i`=7'h11 → AECSR=7'h10 and `aec_exception_o` high for exactly one cycle. Write AECSR=0 in the same cycle as event 7'h10 → AECSR stays 7'h10.
- Access address 14 and address 16'h0800 → no ack for 8 cycles. Write address 2 → ack, and the next read of address 2 is unchanged.
- Assert `rst` during WAIT → no ack, FSM idle, and EVBAR, AECR and AECSR at their reset values on the following cycle.
